// File: rtl/serial_frame_sender.sv
// Single-wire frame serializer: start bit, 2-bit port, 4-bit length, then N payload bits MSB first.
// The line idles high and advances one bit per clkEn strobe.
module serial_frame_sender #(
    parameter int unsigned MAX_LEN = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clkEn,
    input  logic               start,
    input  logic [1:0]         portSel,
    input  logic [3:0]         dataLen,
    input  logic [MAX_LEN-1:0] dataIn,
    output logic               SerOut,
    output logic               busy,
    output logic               ready,
    output logic               done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_PORT  = 3'd2;
    localparam logic [2:0] S_LEN   = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [MAX_LEN-1:0] sh_q, sh_d;
    logic [3:0]         len_q, len_d;
    logic [1:0]         port_q, port_d;
    logic               ser_q, ser_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic               done_q, done_d;
    logic [3:0]         cnt_m1_s;
    logic [3:0]         len_m1_s;

    assign cnt_m1_s = bit_cnt_q - 4'd1;
    assign len_m1_s = len_q - 4'd1;

    // Next-state logic; bit_cnt_q holds the index of the bit currently on the line.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
        len_d     = len_q;
        port_d    = port_q;
        ser_d     = ser_q;
        done_d    = 1'b0;
        if (clkEn) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        port_d    = portSel;
                        len_d     = dataLen;
                        sh_d      = dataIn;
                        ser_d     = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = S_START;
                    end else begin
                        ser_d = 1'b1;
                    end
                end
                S_START: begin
                    ser_d     = port_q[1];
                    bit_cnt_d = 4'd1;
                    state_d   = S_PORT;
                end
                S_PORT: begin
                    if (bit_cnt_q != 4'd0) begin
                        ser_d     = port_q[0];
                        bit_cnt_d = 4'd0;
                    end else begin
                        ser_d     = len_q[3];
                        bit_cnt_d = 4'd3;
                        state_d   = S_LEN;
                    end
                end
                S_LEN: begin
                    if (bit_cnt_q != 4'd0) begin
                        ser_d     = len_q[cnt_m1_s[1:0]];
                        bit_cnt_d = cnt_m1_s;
                    end else if (len_q == 4'd0) begin
                        ser_d     = 1'b1;
                        done_d    = 1'b1;
                        bit_cnt_d = 4'd0;
                        state_d   = S_IDLE;
                    end else begin
                        ser_d     = sh_q[len_m1_s];
                        bit_cnt_d = len_m1_s;
                        state_d   = S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_cnt_q != 4'd0) begin
                        ser_d     = sh_q[cnt_m1_s];
                        bit_cnt_d = cnt_m1_s;
                    end else begin
                        ser_d     = 1'b1;
                        done_d    = 1'b1;
                        bit_cnt_d = 4'd0;
                        state_d   = S_IDLE;
                    end
                end
                default: begin
                    ser_d     = 1'b1;
                    bit_cnt_d = 4'd0;
                    state_d   = S_IDLE;
                end
            endcase
        end else begin
            done_d = 1'b0;
        end
        busy_d  = (state_d != S_IDLE);
        ready_d = ~busy_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 4'd0;
            sh_q      <= '0;
            len_q     <= 4'd0;
            port_q    <= 2'd0;
            ser_q     <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            len_q     <= len_d;
            port_q    <= port_d;
            ser_q     <= ser_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    assign SerOut = ser_q;
    assign busy   = busy_q;
    assign ready  = ready_q;
    assign done   = done_q;

endmodule

// File: doc/serial_frame_sender.md
# serial_frame_sender

Serializer that produces the single-wire frame consumed by the port-demultiplexing serial receiver on `SerIn`. It sends a start bit, a 2-bit destination port, a 4-bit data length N, and N data bits. It sits on the source side of the link, driven by a host or stimulus controller, and shares the receiver's clock and `clkEn` bit-rate strobe. Line idles high.

## Interface
Parameters:
- `MAX_LEN`, 15: largest legal data length. Fixed by the 4-bit length field; not meant to be overridden.

Ports:
- `clk`, in, 1: system clock. All logic on the rising edge.
- `rst`, in, 1: synchronous reset, active-low. Sampled on `clk` rising edge.
- `clkEn`, in, 1: bit strobe. State and bit advance only on edges where `clkEn`=1.
- `start`, in, 1: frame request. Sampled only in IDLE with `clkEn`=1.
- `portSel`, in, 2: destination port, 0..3.
- `dataLen`, in, 4: number of data bits N, 0..15.
- `dataIn`, in, 15: payload. Bits `dataIn[N-1:0]` are sent; upper bits are ignored.
- `SerOut`, out, 1: serial line. Registered. 1 when idle.
- `busy`, out, 1: high while a frame is on the line.
- `ready`, out, 1: high in IDLE. Equal to ~`busy`.
- `done`, out, 1: one-`clk` pulse when a frame completes.

## Operation
- States: IDLE, START, PORT, LEN, DATA. 4-bit `bitCnt`, 15-bit shift register `sh`, 4-bit length register `len`.
- IDLE: `SerOut`=1 and `busy`=0.
  - On `start`=1 with `clkEn`=1: latch `portSel`, `dataLen`, `dataIn`, then go to START.
- START: `SerOut`=0 for one bit period, then go to PORT.
- PORT: send `portSel[1]`, then `portSel[0]`. Bits are sent MSB first. Then go to LEN.
- LEN: send `dataLen[3]` down to `dataLen[0]`.
  - If `len`=0: go to IDLE after `dataLen[0]`.
  - Otherwise: go to DATA.
- DATA: send `dataIn[N-1]` down to `dataIn[0]`, then go to IDLE.
- Frame length: 7+N bit periods. After the frame, at least one idle (1) bit follows before the next start bit.
- `start` while `busy`: ignored. It is not queued.
- Latched operands are immune to input changes mid-frame.
- `dataLen`=0: a legal frame of only header bits. No DATA state is entered.
- `clkEn`=0: all registers hold, `SerOut` is frozen, and a pending `done` is deferred.

## Timing
- Reset (`rst`=0 at an edge): `SerOut`=1, `busy`=0, `ready`=1, `done`=0, state IDLE, `bitCnt`=0. Takes effect the cycle after the edge. An in-progress frame is abandoned and the line returns high immediately. After `rst` returns to 1, the block accepts `start` on the first enabled edge.
- Accept at enabled edge E0: `SerOut`=0 and `busy`=1 from the cycle after E0.
- Each subsequent bit changes on the next enabled edge. Enabled edge Ek (k=1..6+N) presents bit k of the frame.
- Enabled edge E(7+N): state becomes IDLE, `SerOut`=1, `busy`=0, `done`=1 for exactly one `clk` cycle. `done` clears on the next `clk` edge regardless of `clkEn`.
- Back-to-back: `start` sampled at E(7+N+1) is accepted. This gives exactly one idle bit between frames.
- Latency from accepted `start` to first data bit: 7 enabled edges.
- `rst` and `start` asserted together: reset wins.

## Test plan
- Reset mid-frame: start a frame, pull `rst`=0 during DATA -> next cycle `SerOut`=1, `busy`=0, `done`=0. A new frame then starts cleanly.
- `portSel`=3, `dataLen`=0, `clkEn`=1 every cycle -> `SerOut` = 0,1,1,0,0,0,0, then 1. `done` pulses once, 8 cycles after accept. `busy` is high for 7 cycles.
- `portSel`=2, `dataLen`=5, `dataIn`=15'h0016 -> `SerOut` = 0,1,0,0,1,0,1,1,0,1,1,0 (12 bits), then 1. Check that a loopback receiver reports port 2 with payload 10110.
- `clkEn` toggled every other cycle, `portSel`=1, `dataLen`=15, `dataIn`=15'h5555 -> each bit lasts 2 `clk` cycles. Frame is 22 bits. `done` is exactly 1 cycle wide.
- `start` held high continuously with `dataLen`=1 -> frames repeat with exactly one idle bit between them. Changing `dataIn` mid-frame does not alter the current frame.
- `start` pulsed during PORT state -> ignored. Exactly one frame is sent and exactly one `done` occurs.
